// File: rtl/construtor_caminho_if.sv
// Bundle of the path builder's control, predecessor-memory read port and path-output handshake.
// master is the construtor_caminho side; slave is the controller/memory/consumer side.
interface construtor_caminho_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  iniciar_in;
  logic [ADDR_WIDTH-1:0] fonte_in;
  logic [ADDR_WIDTH-1:0] destino_in;
  logic                  mem_rd_en_out;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_out;
  logic [ADDR_WIDTH-1:0] mem_rd_data_in;
  logic                  caminho_valid_out;
  logic [ADDR_WIDTH-1:0] caminho_addr_out;
  logic                  caminho_lido_in;
  logic                  ocupado_out;
  logic                  caminho_pronto_out;
  logic [LEN_WIDTH-1:0]  caminho_tamanho_out;
  logic                  erro_out;

  modport master (
    input  iniciar_in, fonte_in, destino_in, mem_rd_data_in, caminho_lido_in,
    output mem_rd_en_out, mem_rd_addr_out, caminho_valid_out, caminho_addr_out,
    output ocupado_out, caminho_pronto_out, caminho_tamanho_out, erro_out
  );

  modport slave (
    output iniciar_in, fonte_in, destino_in, mem_rd_data_in, caminho_lido_in,
    input  mem_rd_en_out, mem_rd_addr_out, caminho_valid_out, caminho_addr_out,
    input  ocupado_out, caminho_pronto_out, caminho_tamanho_out, erro_out
  );
endinterface

// File: rtl/construtor_caminho.sv
// Walks the predecessor memory from destino back to fonte, emitting each node over valid/lido.
// Define CONSTRUTOR_CAMINHO_LIMITE_EN to enable the MAX_PASSOS runaway-loop guard (ERRO state).
module construtor_caminho #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int unsigned MAX_PASSOS = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  construtor_caminho_if.master  bus
);

  typedef enum logic [2:0] {
    StOcioso,
    StEmitir,
    StEspera,
`ifdef CONSTRUTOR_CAMINHO_LIMITE_EN
    StErro,
`endif
    StFim
  } estado_e;

  estado_e               r_estado, w_estado_d;
  logic [ADDR_WIDTH-1:0] r_atual, w_atual_d;
  logic [ADDR_WIDTH-1:0] r_fonte, w_fonte_d;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_d;
  logic [LEN_WIDTH-1:0]  r_tamanho, w_tamanho_d;
  logic                  w_rd_en;
  logic                  w_transfer;
  logic [LEN_WIDTH-1:0]  w_tamanho_inc;

  assign w_transfer    = (r_estado == StEmitir) && bus.caminho_lido_in;
  // Saturate instead of wrapping so a huge walk never reports a short length.
  assign w_tamanho_inc = (&r_tamanho) ? r_tamanho : r_tamanho + 1'b1;

  always_comb begin
    w_estado_d  = r_estado;
    w_atual_d   = r_atual;
    w_fonte_d   = r_fonte;
    w_rd_addr_d = r_rd_addr;
    w_tamanho_d = r_tamanho;
    w_rd_en     = 1'b0;
    case (r_estado)
      StEmitir: begin
        if (w_transfer) begin
          w_tamanho_d = w_tamanho_inc;
          if (r_atual == r_fonte) begin
            w_estado_d = StFim;
          end
`ifdef CONSTRUTOR_CAMINHO_LIMITE_EN
          else if (32'(r_tamanho) + 32'd1 == MAX_PASSOS) begin
            w_estado_d = StErro;
          end
`endif
          else begin
            w_rd_en     = 1'b1;
            w_rd_addr_d = r_atual;
            w_estado_d  = StEspera;
          end
        end
      end
      StEspera: begin
        w_atual_d  = bus.mem_rd_data_in;
        w_estado_d = StEmitir;
      end
      // Idle, done and error all accept a fresh start.
      default: begin
        if (bus.iniciar_in) begin
          w_fonte_d   = bus.fonte_in;
          w_atual_d   = bus.destino_in;
          w_tamanho_d = '0;
          w_estado_d  = StEmitir;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= StOcioso;
      r_atual   <= '0;
      r_fonte   <= '0;
      r_rd_addr <= '0;
      r_tamanho <= '0;
    end else begin
      r_estado  <= w_estado_d;
      r_atual   <= w_atual_d;
      r_fonte   <= w_fonte_d;
      r_rd_addr <= w_rd_addr_d;
      r_tamanho <= w_tamanho_d;
    end
  end

  assign bus.mem_rd_en_out       = w_rd_en;
  assign bus.mem_rd_addr_out     = w_rd_addr_d;
  assign bus.caminho_valid_out   = (r_estado == StEmitir);
  assign bus.caminho_addr_out    = r_atual;
  assign bus.ocupado_out         = (r_estado == StEmitir) || (r_estado == StEspera);
  assign bus.caminho_pronto_out  = (r_estado == StFim);
  assign bus.caminho_tamanho_out = r_tamanho;
`ifdef CONSTRUTOR_CAMINHO_LIMITE_EN
  assign bus.erro_out            = (r_estado == StErro);
`else
  assign bus.erro_out            = 1'b0;
`endif

endmodule

// File: doc/construtor_caminho.md
# construtor_caminho

Path-reconstruction controller for the pathfinding accelerator. Once the state controller asserts its construct-path phase, this block walks the predecessor ("anterior") memory backwards from `destino` to `fonte`. It issues one synchronous read per hop and presents each node address to the external consumer over a valid/acknowledge handshake. It owns the read port of the predecessor memory and reports completion, path length and a runaway-loop error.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, node address width.
- `LEN_WIDTH`, `ADDR_WIDTH+1`, width of the path-length counter.
- `MAX_PASSOS`, `1<<ADDR_WIDTH`, maximum node count before declaring a loop. Only used with `CONSTRUTOR_CAMINHO_LIMITE_EN`.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `iniciar_in`  in  1  start pulse, driven from `cme_construir_caminho`.
- `fonte_in`  in  ADDR_WIDTH  source node. Sampled on accepted start.
- `destino_in`  in  ADDR_WIDTH  destination node. Sampled on accepted start.
- `mem_rd_en_out`  out  1  predecessor memory read enable.
- `mem_rd_addr_out`  out  ADDR_WIDTH  predecessor memory read address.
- `mem_rd_data_in`  in  ADDR_WIDTH  predecessor of the addressed node. Valid one cycle after `mem_rd_en_out`.
- `caminho_valid_out`  out  1  `caminho_addr_out` holds a path node.
- `caminho_addr_out`  out  ADDR_WIDTH  current path node, emitted destination first.
- `caminho_lido_in`  in  1  consumer acknowledge. A node transfers when valid and lido are both high.
- `ocupado_out`  out  1  high in every state except OCIOSO, FIM and ERRO.
- `caminho_pronto_out`  out  1  level, high in FIM.
- `caminho_tamanho_out`  out  LEN_WIDTH  number of nodes transferred so far.
- `erro_out`  out  1  level, high in ERRO.

## Operation
State machine: OCIOSO, EMITIR, ESPERA, FIM, ERRO.

- **OCIOSO**
  - `iniciar_in=1`: latch `fonte_in`, `destino_in`; load `atual` with `destino_in`; clear the counter; go to EMITIR.
- **EMITIR**
  - `caminho_valid_out=1` and `caminho_addr_out=atual`. Valid and address stay stable until acknowledged.
  - On transfer, the counter increments. Next action on that same transfer:
    - if `atual==fonte`, go to FIM;
    - else, with the macro, if counter+1 `==MAX_PASSOS`, go to ERRO;
    - else assert `mem_rd_en_out` with `mem_rd_addr_out=atual` in that same cycle and go to ESPERA.
- **ESPERA**
  - Register `atual <= mem_rd_data_in`; go to EMITIR.
- **FIM / ERRO**
  - Hold outputs.
  - `iniciar_in` restarts exactly as from OCIOSO, clearing `erro_out` and `caminho_pronto_out`.

Rules:
- `iniciar_in` is ignored while `ocupado_out=1`.
- `fonte==destino`: one node is emitted, `caminho_tamanho_out=1`, then FIM. No memory read occurs.
- The counter saturates at all-ones. It never wraps.
- `mem_rd_en_out` is a single-cycle pulse. It is only asserted on an EMITIR transfer that does not end the walk.
- `mem_rd_addr_out` holds its last value when not reading.

## Timing
- Reset values: state OCIOSO, all outputs 0, `atual`/`fonte`/`destino` 0.
- Reset mid-walk aborts immediately; no partial outputs remain.
- Start to first valid: 1 cycle. `iniciar_in` at edge N gives valid from cycle N+1.
- With `caminho_lido_in` held high, one node transfers every 2 cycles (EMITIR, ESPERA).
- Last transfer to `caminho_pronto_out`: 1 cycle.
- Consumer stall in EMITIR is unbounded. The memory is not read while stalled.

## Configuration
- `CONSTRUTOR_CAMINHO_LIMITE_EN` defined:
  - the counter is compared against `MAX_PASSOS`;
  - ERRO is reachable, which protects against cyclic or uninitialised predecessor data.
- Undefined:
  - no limit comparison and no ERRO state; `erro_out` tied 0;
  - the walk continues until `atual==fonte`.

## Test plan
- **Basic path:** memory 7→3, 3→1; fonte=1, destino=7, lido tied 1 → nodes 7, 3, 1 on cycles 1, 3, 5; pronto high at cycle 6; tamanho=3; 2 reads, to addresses 7 and 3.
- **Trivial path:** fonte=destino=5 → single node 5, tamanho=1, pronto; `mem_rd_en_out` never asserted.
- **Backpressure:** basic path with lido low for 4 cycles on node 3 → addr stays 3 with valid held; no read issued until acknowledged; final sequence unchanged.
- **Loop guard (macro on, MAX_PASSOS=4):** memory 2→6, 6→2; fonte=9, destino=2 → nodes 2, 6, 2, 6, then erro_out=1, pronto=0, tamanho=4.
- **Busy and reset:** iniciar pulsed mid-walk → ignored. rst_n low mid-walk → all outputs 0 and state OCIOSO next cycle; a new start then produces the correct path.
- **Macro off:** the loop scenario keeps emitting beyond 4 nodes; erro_out stays 0.
